// File: rtl/bin2bcd_stream_if.sv
// Valid/ready stream bundle for bin2bcd_stream: the binary operand on the input side,
// and the BCD result with its status flags on the output side.
interface bin2bcd_stream_if #(
  parameter int unsigned BIN_WIDTH  = 16,
  parameter int unsigned DEC_DIGITS = 5
);
  localparam int unsigned UsedW = $clog2(DEC_DIGITS + 1);

  logic [BIN_WIDTH-1:0]    data_bin;
  logic                    in_valid;
  logic                    in_ready;
  logic [DEC_DIGITS*4-1:0] data_bcd;
  logic                    sign;
  logic                    overflow;
  logic [UsedW-1:0]        digits_used;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  data_bin, in_valid, out_ready,
    output in_ready, data_bcd, sign, overflow, digits_used, out_valid
  );

  modport master (
    output data_bin, in_valid, out_ready,
    input  in_ready, data_bcd, sign, overflow, digits_used, out_valid
  );
endinterface

// File: rtl/bin2bcd_stream.sv
// Handshaked double-dabble binary-to-BCD converter. Performs one shift-and-add-3 iteration
// per cycle, with every digit adjusted in parallel.
module bin2bcd_stream #(
  parameter int unsigned BIN_WIDTH  = 16,
  parameter int unsigned DEC_DIGITS = 5,
  parameter bit          SIGNED     = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  bin2bcd_stream_if.slave s_io
);

  localparam int unsigned BcdW  = DEC_DIGITS * 4;
  localparam int unsigned CntW  = $clog2(BIN_WIDTH + 1);
  localparam int unsigned UsedW = $clog2(DEC_DIGITS + 1);

  typedef enum logic [1:0] {StIdle, StConvert, StValid} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;

  logic                 neg;
  logic [BIN_WIDTH-1:0] magnitude;
  logic [BcdW-1:0]      bcd_adj;
  logic [UsedW-1:0]     digits_used;

  // Negating the most-negative value wraps back to 2^(BIN_WIDTH-1); read as unsigned, this
  // is the correct magnitude.
  always_comb begin
    neg       = SIGNED && s_io.data_bin[BIN_WIDTH-1];
    magnitude = neg ? -s_io.data_bin : s_io.data_bin;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    digits_used = UsedW'(1);
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) begin
        digits_used = UsedW'(i + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (s_io.in_valid) begin
          shift_d = magnitude;
          bcd_d   = '0;
          cnt_d   = '0;
          sign_d  = neg;
          ovf_d   = 1'b0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        // A carry out of the top digit means the value no longer fits; keep it sticky.
        bcd_d   = {bcd_adj[BcdW-2:0], shift_q[BIN_WIDTH-1]};
        shift_d = {shift_q[BIN_WIDTH-2:0], 1'b0};
        ovf_d   = ovf_q | bcd_adj[BcdW-1];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BIN_WIDTH - 1)) begin
          state_d = StValid;
        end
      end
      StValid: begin
        if (s_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  assign s_io.in_ready    = (state_q == StIdle);
  assign s_io.out_valid   = (state_q == StValid);
  assign s_io.data_bcd    = bcd_q;
  assign s_io.sign        = sign_q;
  assign s_io.overflow    = ovf_q;
  assign s_io.digits_used = digits_used;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Directed bench: three converters (default, 4-digit, signed) driven in lockstep.
module tb_bin2bcd_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  bin2bcd_stream_if #(.BIN_WIDTH(16), .DEC_DIGITS(5)) if_def ();
  bin2bcd_stream_if #(.BIN_WIDTH(16), .DEC_DIGITS(4)) if_d4 ();
  bin2bcd_stream_if #(.BIN_WIDTH(16), .DEC_DIGITS(5)) if_sgn ();

  bin2bcd_stream #(.BIN_WIDTH(16), .DEC_DIGITS(5), .SIGNED(1'b0)) u_def (
    .clk(clk), .rst_n(rst_n), .s_io(if_def)
  );
  bin2bcd_stream #(.BIN_WIDTH(16), .DEC_DIGITS(4), .SIGNED(1'b0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .s_io(if_d4)
  );
  bin2bcd_stream #(.BIN_WIDTH(16), .DEC_DIGITS(5), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .s_io(if_sgn)
  );

  always #5 clk = ~clk;

  logic [19:0] bcd_def, bcd_sgn;
  logic [15:0] bcd_d4;
  logic [2:0]  used_def, used_d4, used_sgn;
  logic        ovf_def, ovf_d4, sign_def, sign_sgn;
  int          lat;

  task automatic set_in(input logic v, input logic [15:0] d);
    if_def.in_valid = v;  if_def.data_bin = d;
    if_d4.in_valid  = v;  if_d4.data_bin  = d;
    if_sgn.in_valid = v;  if_sgn.data_bin = d;
  endtask

  task automatic set_ready(input logic r);
    if_def.out_ready = r;
    if_d4.out_ready  = r;
    if_sgn.out_ready = r;
  endtask

  // Entered at posedge+1 with all converters idle.
  task automatic convert(input logic [15:0] d, input bit release_out);
    set_in(1'b1, d);
    @(posedge clk); #1;
    set_in(1'b0, ~d);
    n_checks++;
    if (if_def.in_ready !== 1'b0) $display("FAIL accept_drops_ready: got %b want 0", if_def.in_ready);
    else n_pass++;
    lat = 0;
    while (if_def.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (if_def.out_valid !== 1'b1) $display("FAIL convert_timeout: got %b want 1", if_def.out_valid);
    else n_pass++;
    bcd_def = if_def.data_bcd; used_def = if_def.digits_used;
    ovf_def = if_def.overflow;  sign_def = if_def.sign;
    bcd_d4  = if_d4.data_bcd;  used_d4  = if_d4.digits_used;  ovf_d4 = if_d4.overflow;
    bcd_sgn = if_sgn.data_bcd; used_sgn = if_sgn.digits_used; sign_sgn = if_sgn.sign;
    if (release_out) begin
      set_ready(1'b1);
      @(posedge clk); #1;
      set_ready(1'b0);
      n_checks++;
      if (if_def.out_valid !== 1'b0 || if_def.in_ready !== 1'b1)
        $display("FAIL release_idle: got valid=%b ready=%b want valid=0 ready=1",
                 if_def.out_valid, if_def.in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    set_in(1'b0, 16'h0);
    set_ready(1'b0);
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (if_def.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", if_def.in_ready);
    else n_pass++;
    n_checks++;
    if (if_def.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", if_def.out_valid);
    else n_pass++;
    n_checks++;
    if (if_def.data_bcd !== 20'h0) $display("FAIL reset_bcd: got %h want 00000", if_def.data_bcd);
    else n_pass++;
    n_checks++;
    if (if_def.digits_used !== 3'd1) $display("FAIL reset_used: got %0d want 1", if_def.digits_used);
    else n_pass++;
    n_checks++;
    if (if_def.overflow !== 1'b0 || if_sgn.sign !== 1'b0)
      $display("FAIL reset_flags: got ovf=%b sign=%b want 0 0", if_def.overflow, if_sgn.sign);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    convert(16'hFFFF, 1'b1);
    n_checks++;
    if (lat !== 16) $display("FAIL latency_ffff: got %0d want 16", lat);
    else n_pass++;
    n_checks++;
    if (bcd_def !== 20'h65535) $display("FAIL bcd_ffff: got %h want 65535", bcd_def);
    else n_pass++;
    n_checks++;
    if (used_def !== 3'd5 || ovf_def !== 1'b0 || sign_def !== 1'b0)
      $display("FAIL flags_ffff: got used=%0d ovf=%b sign=%b want 5 0 0", used_def, ovf_def, sign_def);
    else n_pass++;
    n_checks++;
    if (bcd_d4 !== 16'h5535 || ovf_d4 !== 1'b1 || used_d4 !== 3'd4)
      $display("FAIL d4_ffff: got %h ovf=%b used=%0d want 5535 1 4", bcd_d4, ovf_d4, used_d4);
    else n_pass++;

    convert(16'd0, 1'b1);
    n_checks++;
    if (bcd_def !== 20'h00000 || used_def !== 3'd1)
      $display("FAIL zero: got %h used=%0d want 00000 1", bcd_def, used_def);
    else n_pass++;
    convert(16'd9, 1'b1);
    n_checks++;
    if (bcd_def !== 20'h00009 || used_def !== 3'd1)
      $display("FAIL nine: got %h used=%0d want 00009 1", bcd_def, used_def);
    else n_pass++;
    convert(16'd10, 1'b1);
    n_checks++;
    if (bcd_def !== 20'h00010 || used_def !== 3'd2)
      $display("FAIL ten: got %h used=%0d want 00010 2", bcd_def, used_def);
    else n_pass++;
  endtask

  task automatic test_overflow();
    convert(16'd12345, 1'b1);
    n_checks++;
    if (bcd_d4 !== 16'h2345 || ovf_d4 !== 1'b1)
      $display("FAIL ovf_12345: got %h ovf=%b want 2345 1", bcd_d4, ovf_d4);
    else n_pass++;
    n_checks++;
    if (bcd_def !== 20'h12345 || ovf_def !== 1'b0)
      $display("FAIL def_12345: got %h ovf=%b want 12345 0", bcd_def, ovf_def);
    else n_pass++;
    convert(16'd9999, 1'b1);
    n_checks++;
    if (bcd_d4 !== 16'h9999 || ovf_d4 !== 1'b0 || used_d4 !== 3'd4)
      $display("FAIL ovf_9999: got %h ovf=%b used=%0d want 9999 0 4", bcd_d4, ovf_d4, used_d4);
    else n_pass++;
  endtask

  task automatic test_signed();
    convert(16'h8000, 1'b1);
    n_checks++;
    if (bcd_sgn !== 20'h32768 || sign_sgn !== 1'b1)
      $display("FAIL sgn_8000: got %h sign=%b want 32768 1", bcd_sgn, sign_sgn);
    else n_pass++;
    convert(16'hFFFF, 1'b1);
    n_checks++;
    if (bcd_sgn !== 20'h00001 || sign_sgn !== 1'b1 || used_sgn !== 3'd1)
      $display("FAIL sgn_ffff: got %h sign=%b used=%0d want 00001 1 1", bcd_sgn, sign_sgn, used_sgn);
    else n_pass++;
    convert(16'h7FFF, 1'b1);
    n_checks++;
    if (bcd_sgn !== 20'h32767 || sign_sgn !== 1'b0)
      $display("FAIL sgn_7fff: got %h sign=%b want 32767 0", bcd_sgn, sign_sgn);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    convert(16'h1234, 1'b0);
    n_checks++;
    if (bcd_def !== 20'h04660) $display("FAIL bp_value: got %h want 04660", bcd_def);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 16'h0042);
      @(posedge clk); #1;
      n_checks++;
      if (if_def.out_valid !== 1'b1 || if_def.in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got valid=%b ready=%b want 1 0", i, if_def.out_valid,
                 if_def.in_ready);
      else n_pass++;
      n_checks++;
      if (if_def.data_bcd !== 20'h04660)
        $display("FAIL bp_stable_%0d: got %h want 04660", i, if_def.data_bcd);
      else n_pass++;
    end
    set_in(1'b0, 16'h0);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    n_checks++;
    if (if_def.in_ready !== 1'b1 || if_def.out_valid !== 1'b0)
      $display("FAIL bp_release: got ready=%b valid=%b want 1 0", if_def.in_ready, if_def.out_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (if_def.in_ready !== 1'b1) $display("FAIL bp_no_accept: got %b want 1", if_def.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    set_in(1'b1, 16'd1234);
    @(posedge clk); #1;
    set_in(1'b0, 16'h0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (if_def.out_valid !== 1'b0 || if_def.in_ready !== 1'b1)
      $display("FAIL rst_mid_state: got valid=%b ready=%b want 0 1", if_def.out_valid, if_def.in_ready);
    else n_pass++;
    n_checks++;
    if (if_def.data_bcd !== 20'h0 || if_def.digits_used !== 3'd1 || if_def.overflow !== 1'b0)
      $display("FAIL rst_mid_outputs: got %h used=%0d ovf=%b want 00000 1 0", if_def.data_bcd,
               if_def.digits_used, if_def.overflow);
    else n_pass++;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (if_def.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL rst_mid_no_valid: got %0d want 0", seen);
    else n_pass++;
    convert(16'd4321, 1'b1);
    n_checks++;
    if (bcd_def !== 20'h04321) $display("FAIL after_rst: got %h want 04321", bcd_def);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic [19:0] outs [3];
    int          acc [3];
    int          na, no;
    bit          take;
    vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd300;
    na = 0; no = 0;
    for (int k = 0; k < 3; k++) begin
      acc[k] = 0;
      outs[k] = '0;
    end
    set_ready(1'b1);
    set_in(1'b1, vals[0]);
    for (int cyc = 0; cyc < 60; cyc++) begin
      take = (if_def.in_ready === 1'b1) && (na < 3);
      if (if_def.out_valid === 1'b1 && no < 3) begin
        outs[no] = if_def.data_bcd;
        no++;
      end
      if (take) begin
        acc[na] = cyc;
        na++;
      end
      @(posedge clk); #1;
      if (take) begin
        if (na < 3) set_in(1'b1, vals[na]);
        else set_in(1'b0, 16'h0);
      end
    end
    set_ready(1'b0);
    set_in(1'b0, 16'h0);
    n_checks++;
    if (na !== 3 || no !== 3) $display("FAIL b2b_counts: got acc=%0d out=%0d want 3 3", na, no);
    else n_pass++;
    n_checks++;
    if (acc[1] - acc[0] !== 18) $display("FAIL b2b_period_1: got %0d want 18", acc[1] - acc[0]);
    else n_pass++;
    n_checks++;
    if (acc[2] - acc[1] !== 18) $display("FAIL b2b_period_2: got %0d want 18", acc[2] - acc[1]);
    else n_pass++;
    n_checks++;
    if (outs[0] !== 20'h00100 || outs[1] !== 20'h00200 || outs[2] !== 20'h00300)
      $display("FAIL b2b_values: got %h %h %h want 00100 00200 00300", outs[0], outs[1], outs[2]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_overflow();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_stream.md
# bin2bcd_stream

Parametrised, handshaked binary-to-BCD converter using double dabble (shift-and-add-3). Adds over the earlier converter: all digits adjusted in one cycle, valid/ready on both sides, optional signed input, overflow detection, and a significant-digit count. Sits between arithmetic datapaths and display/UART formatting logic.

## Interface

- BIN_WIDTH, 16: binary input width; legal range 2..32.
- DEC_DIGITS, 5: BCD output digits; legal range 1..10.
- SIGNED, 0: 1 = DataBin is two's complement; 0 = unsigned.
- Clk  input  1  clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- DataBin  input  BIN_WIDTH  binary operand; sampled on input handshake.
- InValid  input  1  DataBin valid.
- InReady  output  1  converter can accept; high only in IDLE.
- DataBCD  output  DEC_DIGITS*4  result; digit 0 in bits [3:0].
- Sign  output  1  1 = negative input (SIGNED=1 only; tied 0 otherwise).
- Overflow  output  1  magnitude exceeds 10^DEC_DIGITS-1.
- DigitsUsed  output  $clog2(DEC_DIGITS+1)  index of highest non-zero digit + 1; 1 for zero.
- OutValid  output  1  DataBCD/Sign/Overflow/DigitsUsed valid.
- OutReady  input  1  downstream accepts result.

## Operation

- States: IDLE, CONVERT, VALID.
- IDLE: InReady=1. On InValid=1: latch magnitude into shift register, clear BCD register, Overflow and iteration counter, latch Sign; go CONVERT.
- Magnitude: SIGNED=1 and DataBin[MSB]=1 → two's-complement negation, BIN_WIDTH bits wide (most-negative value yields 2^(BIN_WIDTH-1), fits unsigned). Otherwise DataBin unchanged; Sign=0.
- CONVERT, one iteration per cycle: every digit ≥5 gets +3 (all in parallel, combinational), then {BCD, shift} shifted left 1; binary MSB enters BCD bit 0. Bit shifted out of BCD MSB ORed into sticky Overflow.
- Counter increments per iteration; after iteration BIN_WIDTH go VALID.
- VALID: OutValid=1; all outputs held stable. On OutReady=1 go IDLE.
- Overflow=1: DataBCD holds result modulo 10^DEC_DIGITS (low digits exact); DigitsUsed computed from that truncated value.
- DigitsUsed: combinational from BCD register; meaningful only while OutValid=1.
- Illegal state encoding → IDLE.

## Timing

- Reset (async assert, Clk-synchronous release irrelevant to function): state IDLE, DataBCD=0, Sign=0, Overflow=0, OutValid=0, InReady=1, DigitsUsed=1.
- Input accepted on edge E0 where InValid&&InReady; InReady low from E0 onward.
- OutValid rises after edge E0+BIN_WIDTH (latency BIN_WIDTH cycles).
- Output handshake on edge where OutValid&&OutReady; OutValid low and InReady high next cycle.
- Minimum period between accepted inputs: BIN_WIDTH+2 cycles (OutReady held 1).
- InValid while busy: ignored; upstream must hold data (standard valid/ready).
- OutReady asserted before OutValid: no effect.
- Reset mid-CONVERT or mid-VALID: conversion discarded, no OutValid pulse, IDLE immediately.
- DataBin changes after accept: no effect on result.

## Test plan

- Unsigned max, default params: DataBin=0xFFFF, OutReady=1 → OutValid exactly 16 cycles after accept, DataBCD=0x65535, DigitsUsed=5, Overflow=0.
- Zero and small: DataBin=0 → DataBCD=0x00000, DigitsUsed=1; DataBin=9 → 0x00009, DigitsUsed=1; DataBin=10 → 0x00010, DigitsUsed=2.
- Overflow, DEC_DIGITS=4: DataBin=12345 → DataBCD=0x2345, Overflow=1; DataBin=9999 → 0x9999, Overflow=0.
- Signed, SIGNED=1, BIN_WIDTH=16: 0x8000 → 0x32768 Sign=1; 0xFFFF → 0x00001 Sign=1; 0x7FFF → 0x32767 Sign=0.
- Backpressure: OutReady=0 for 5 cycles after OutValid → outputs stable, InReady=0, new InValid ignored; OutReady=1 → IDLE next cycle, back-to-back inputs accepted every 18 cycles.
- Reset mid-conversion: assert Rst_n=0 at iteration 7 of DataBin=1234 → outputs at reset values, no OutValid; next input 4321 → 0x04321.
